spi_slave_sync: RTL and testbench
=================================

# spi_slave_sync

Parametrised SPI slave that oversamples the external SPI pins in the system clock domain. It supports all four CPOL/CPHA modes, configurable word width and bit order, and multi-word transfers within one SS frame. It sits between the board-level SPI pins and on-chip logic: a single-entry TX holding buffer with a ready/load handshake on one side, and a one-cycle RX strobe on the other. It supersedes the SCLK-clocked 8-bit slave.

## Interface
- `WIDTH`, default 8: bits per word, at least 2.
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `MSB_FIRST`, default 1: 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth on SCLK, MOSI and SS, at least 2.

Ports:
- `clk`  in  1: system clock. One clock only, the sole clock of the block.
- `rst`  in  1: synchronous, active-high reset.
- `SCLK`  in  1: SPI clock, asynchronous to `clk`.
- `MOSI`  in  1: master-out data.
- `MISO`  out  1: slave-out data. Driven low while SS is high; never tristated.
- `SS`  in  1: slave select, active low.
- `tx_data`  in  WIDTH: next word to transmit.
- `tx_load`  in  1: writes `tx_data` into the TX buffer when `tx_ready` is 1.
- `tx_ready`  out  1: TX buffer empty.
- `rx_data`  out  WIDTH: last complete received word.
- `rx_valid`  out  1: one-cycle strobe; `rx_data` is updated in the same cycle.
- `busy`  out  1: SS (synchronised) is asserted.
- `tx_underrun`  out  1: sticky flag; set when a word starts while the TX buffer is empty.

## Operation
- **Synchronisers:** SCLK, MOSI and SS each pass through SYNC_STAGES flip-flops. A further register on synced SCLK and SS provides edge detection.
- **Edges:** the leading edge is rising when CPOL=0 and falling when CPOL=1. The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other one.
- **State IDLE** (synced SS high):
  - bit counter = 0; MISO = 0; no sampling.
  - IDLE → ACTIVE on the synced SS falling edge.
- **Word start:** occurs on entry to ACTIVE and after every completed word.
  - The TX shift register loads the buffer content and the buffer becomes empty (`tx_ready` = 1 next cycle).
  - If the buffer is empty, the shift register loads 0 and `tx_underrun` is set.
- **State ACTIVE:**
  - On each sample edge, shift synced MOSI into the RX shift register (direction set by MSB_FIRST) and increment the bit counter.
  - On each shift edge, advance the TX shift register.
  - CPHA=0: the first bit is on MISO from the word start. The shift edge that follows the WIDTH-th sample edge is consumed by the word-start load; it does not advance the register.
  - CPHA=1: the first bit is presented on the first leading edge, i.e. the first shift edge moves the freshly loaded first bit onto MISO rather than advancing.
- **Word complete:** when the bit counter reaches WIDTH on a sample edge:
  - `rx_data` ← assembled word, `rx_valid` pulses for 1 cycle.
  - The counter wraps to 0 and a word start occurs.
  - The frame continues until SS rises.
- **SS rise mid-word:**
  - Partial RX bits are discarded, with no `rx_valid`.
  - The TX word already moved into the shift register is lost; the buffer is not restored.
  - Return to IDLE.
- **TX handshake:**
  - `tx_load` with `tx_ready` = 1: the buffer is filled and `tx_ready` = 0 the next cycle.
  - `tx_load` with `tx_ready` = 0: ignored; the buffer keeps its content.
  - `tx_load` in the same cycle as a word start with the buffer empty: the word start transmits 0 and sets underrun; the loaded value fills the buffer for the next word.
  - `tx_load` while the buffer is full and a word start occurs in the same cycle: the old content goes to the shift register and the load is ignored.
  - `tx_underrun` clears on any accepted `tx_load`. If a new underrun occurs in the same cycle as an accepted `tx_load`, set wins.
- **Reset values:** MISO 0, `rx_data` 0, `rx_valid` 0, `tx_ready` 1, `busy` 0, `tx_underrun` 0, state IDLE, counters 0, synchronisers 0 (SCLK stages reset to CPOL).

## Timing
- Input-to-action latency is SYNC_STAGES+1 `clk` cycles from a pin edge.
- MISO changes SYNC_STAGES+2 cycles after a shift-edge pin transition.
- SCLK high time and low time must each be at least SYNC_STAGES+3 `clk` cycles, which gives SCLK max = clk/10 at default.
- After SS falls, the first SCLK edge must come at least SYNC_STAGES+3 cycles later.
- `rx_valid` asserts SYNC_STAGES+2 cycles after the WIDTH-th sample-edge pin transition.
- `busy` follows the pin SS with SYNC_STAGES+1 cycles latency, inverted.

## Test plan
- **Mode 0, 8-bit, MSB first:** `tx_load` 0xA5 before SS falls; master sends 0x3C → MISO bit stream 1,0,1,0,0,1,0,1; `rx_data` = 0x3C; one `rx_valid` pulse; `tx_ready` = 1 after SS falls.
- **All four CPOL/CPHA modes, WIDTH=16, MSB_FIRST=0:** master sends 0x1234 while slave sends 0xBEEF → each side receives the other's word exactly.
- **Two-word frame:** load 0x11, then reload 0x22 once `tx_ready` rises; master sends 0x81 then 0x7E without raising SS → MISO carries 0x11 then 0x22; two `rx_valid` pulses with 0x81 and 0x7E; `tx_underrun` stays 0.
- **Underrun:** no load before SS falls → MISO all 0, `tx_underrun` = 1; next `tx_load` clears it; a load attempted while `tx_ready` = 0 does not change the buffer.
- **Abort:** SS rises after 5 bits → no `rx_valid`, `busy` = 0, MISO = 0; the next full frame receives correctly starting at bit 0.
- **Reset mid-frame:** assert `rst` for 1 cycle after 3 bits → all outputs at reset values next cycle; the frame is ignored until SS is released and asserted again.

Source files
------------

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the system clock domain.
// SCLK, MOSI and SS are synchronised into clk, edges are detected on the
// synchronised copies, and all shifting happens on clk. Supports the four
// CPOL/CPHA modes, either bit order and back-to-back words within one frame.
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             SS,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun
);

  localparam int   CNT_W     = $clog2(WIDTH);
  localparam logic SCLK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic PHASE1    = (CPHA != 0) ? 1'b1 : 1'b0;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Bit that is on the wire first for a given word.
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Move the next TX bit into the output position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // Insert a received bit so that the first bit ends up at the proper end.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic b);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
  endfunction

  // Synchronisers and edge-detect registers
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  // Control state
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full_q, full_d;
  logic                   underrun_q, underrun_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   cur_q, cur_d;
  logic                   skip_q, skip_d;
  logic                   miso_q, miso_d;

  // Datapath (no reset needed: qualified by control state before use)
  logic [WIDTH-1:0]       tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0]       rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0]       buf_q, buf_d;

  // Decoded events
  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ss_fall;
  logic frame_start, in_word, do_sample, do_shift, word_done, word_start;
  logic accept;
  logic [WIDTH-1:0] load_word;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
  assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
  assign sample_edge = PHASE1 ? trail_edge : lead_edge;
  assign shift_edge  = PHASE1 ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_s & ss_prev_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: enter on synced SS falling edge, leave whenever SS is high
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ss_fall) state_d = S_ACTIVE;
      S_ACTIVE: if (ss_s)    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: frame/word events qualified by state
  always_comb begin
    busy        = (state_q == S_ACTIVE);
    frame_start = (state_q == S_IDLE) & ss_fall;
    in_word     = (state_q == S_ACTIVE) & ~ss_s;
    do_sample   = in_word & sample_edge;
    do_shift    = in_word & shift_edge;
    word_done   = do_sample & (cnt_q == CNT_W'(WIDTH - 1));
    word_start  = frame_start | word_done;
  end

  assign accept    = tx_load & ~full_q;
  assign load_word = full_q ? buf_q : '0;

  // Next-state logic for synchronisers, counters, buffer and shift registers
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;

    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    done_d     = word_done;
    rx_data_d  = done_q ? rx_sh_q : rx_data_q;
    rx_valid_d = done_q;
    full_d     = full_q;
    buf_d      = buf_q;
    underrun_d = underrun_q;
    tx_sh_d    = tx_sh_q;
    cur_d      = cur_q;
    skip_d     = skip_q;
    miso_d     = cur_q;

    // Bit counter and RX assembly; partial words die with the frame.
    if (!in_word) begin
      cnt_d = '0;
    end else if (do_sample) begin
      rx_sh_d = shift_in(rx_sh_q, mosi_s);
      cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
    end

    // Holding buffer: a word start empties it before a same-cycle load fills
    // it, so a load into an empty buffer always lands for the next word.
    if (word_start) full_d = 1'b0;
    if (accept) begin
      full_d = 1'b1;
      buf_d  = tx_data;
    end

    // Underrun is sticky; a new underrun beats a clearing load.
    if (word_start && !full_q) underrun_d = 1'b1;
    else if (accept)           underrun_d = 1'b0;

    // TX shifter. skip_q marks the one shift edge that must not advance:
    // in mode CPHA=0 the trailing edge after a completed word, in CPHA=1 the
    // leading edge that puts the freshly loaded first bit on the line.
    if (!in_word && !frame_start) begin
      cur_d  = 1'b0;
      skip_d = 1'b0;
    end else if (word_start) begin
      tx_sh_d = load_word;
      skip_d  = PHASE1 | word_done;
      if (!PHASE1) cur_d = first_bit(load_word);
    end else if (do_shift) begin
      if (skip_q) begin
        skip_d = 1'b0;
        if (PHASE1) cur_d = first_bit(tx_sh_q);
      end else begin
        tx_sh_d = advance(tx_sh_q);
        cur_d   = first_bit(advance(tx_sh_q));
      end
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q   <= 1'b0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      cur_q       <= 1'b0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      cur_q       <= cur_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
    buf_q   <= buf_d;
  end

  assign MISO        = miso_q;
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: one 8-bit mode-0 MSB-first slave plus four 16-bit
// LSB-first slaves, one per CPOL/CPHA mode, each driven by a bit-level master.
`timescale 1ns/1ps
module tb_spi_slave_sync;

  localparam int N    = 5;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sclk[N], ss[N], mosi[N], tx_load[N];
  logic [15:0] tx_data[N];
  logic        miso[N], tx_ready[N], rx_valid[N], busy[N], tx_underrun[N];
  logic [7:0]  rx8;
  logic [15:0] rx16[1:N-1];

  int          tests = 0;
  int          fails = 0;
  int          cur_k = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mi;

  spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]), .SS(ss[0]),
    .tx_data(tx_data[0][7:0]), .tx_load(tx_load[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx8), .rx_valid(rx_valid[0]), .busy(busy[0]), .tx_underrun(tx_underrun[0])
  );

  for (genvar g = 1; g < N; g++) begin : g_w16
    spi_slave_sync #(.WIDTH(16), .CPOL((g - 1) / 2), .CPHA((g - 1) % 2), .MSB_FIRST(0),
                     .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .SCLK(sclk[g]), .MOSI(mosi[g]), .MISO(miso[g]), .SS(ss[g]),
      .tx_data(tx_data[g]), .tx_load(tx_load[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx16[g]), .rx_valid(rx_valid[g]), .busy(busy[g]), .tx_underrun(tx_underrun[g])
    );
  end

  function automatic int width_of(input int k); return (k == 0) ? 8 : 16; endfunction
  function automatic int cpol_of(input int k);  return (k == 0) ? 0 : (k - 1) / 2; endfunction
  function automatic int cpha_of(input int k);  return (k == 0) ? 0 : (k - 1) % 2; endfunction
  function automatic bit msb_of(input int k);   return (k == 0); endfunction

  function automatic logic [15:0] rx_of(input int k);
    return (k == 0) ? {8'h00, rx8} : rx16[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Every rx_valid pulse must match the oldest word the master fully sent.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rx_valid[k] === 1'b1) begin
        if (k != cur_k || exp_q.size() == 0) begin
          check($sformatf("rx_unexpected_dut%0d", k), 32'(rx_of(k)), 32'hFFFF_FFFF);
        end else begin
          check($sformatf("rx_word_dut%0d", k), 32'(rx_of(k)), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int k, input logic [15:0] v);
    tx_data[k] = v;
    tx_load[k] = 1'b1;
    cyc(1);
    tx_load[k] = 1'b0;
  endtask

  task automatic ss_low(input int k);
    ss[k] = 1'b0;
    cyc(HALF);
  endtask

  task automatic ss_high(input int k);
    cyc(HALF);
    ss[k] = 1'b1;
    cyc(3 * HALF);
  endtask

  task automatic wait_ready(input int k, input string name);
    int n = 0;
    while (tx_ready[k] !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    check(name, 32'(tx_ready[k]), 32'd1);
  endtask

  // Master side of nbits bit times; returns the MISO bits it sampled.
  task automatic word(input int k, input logic [15:0] mo, input int nbits,
                      output logic [15:0] got);
    int   w   = width_of(k);
    logic pol = (cpol_of(k) != 0);
    int   idx;
    got = '0;
    for (int b = 0; b < nbits; b++) begin
      idx = msb_of(k) ? (w - 1 - b) : b;
      if (cpha_of(k) == 0) begin
        mosi[k] = mo[idx];
        cyc(HALF);
        got[idx] = miso[k];
        sclk[k]  = ~pol;
        cyc(HALF);
        sclk[k] = pol;
      end else begin
        sclk[k] = ~pol;
        mosi[k] = mo[idx];
        cyc(HALF);
        sclk[k]  = pol;
        got[idx] = miso[k];
        cyc(HALF);
      end
    end
  endtask

  task automatic xfer(input int k, input logic [15:0] mo, input logic [15:0] exp_miso,
                      input string name);
    logic [15:0] got;
    exp_q.push_back(mo);
    word(k, mo, width_of(k), got);
    check(name, 32'(got), 32'(exp_miso));
  endtask

  task automatic check_reset_vals(input int k, input string tag);
    check({tag, "_miso"},     32'(miso[k]),        32'd0);
    check({tag, "_rx_data"},  32'(rx_of(k)),       32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid[k]),    32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready[k]),    32'd1);
    check({tag, "_busy"},     32'(busy[k]),        32'd0);
    check({tag, "_underrun"}, 32'(tx_underrun[k]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      sclk[k]    = (cpol_of(k) != 0);
      ss[k]      = 1'b1;
      mosi[k]    = 1'b0;
      tx_load[k] = 1'b0;
      tx_data[k] = '0;
    end
    cyc(4);
    rst = 1'b0;
    cyc(6);
    for (int k = 0; k < N; k++) check_reset_vals(k, $sformatf("reset_dut%0d", k));

    // Mode 0, 8-bit, MSB first
    cur_k = 0;
    load(0, 16'h00A5);
    check("t1_ready_after_load", 32'(tx_ready[0]), 32'd0);
    ss_low(0);
    check("t1_ready_after_ss", 32'(tx_ready[0]), 32'd1);
    check("t1_busy", 32'(busy[0]), 32'd1);
    xfer(0, 16'h003C, 16'h00A5, "t1_miso_stream");
    ss_high(0);
    check("t1_busy_end", 32'(busy[0]), 32'd0);
    check("t1_miso_idle", 32'(miso[0]), 32'd0);
    check("t1_rx_data", 32'(rx_of(0)), 32'h3C);
    check("t1_rx_pending", 32'(exp_q.size()), 32'd0);

    // All four modes, 16-bit, LSB first
    for (int k = 1; k < N; k++) begin
      cur_k = k;
      load(k, 16'hBEEF);
      ss_low(k);
      xfer(k, 16'h1234, 16'hBEEF, $sformatf("t2_miso_mode%0d", k - 1));
      ss_high(k);
      check($sformatf("t2_rx_mode%0d", k - 1), 32'(rx_of(k)), 32'h1234);
      check($sformatf("t2_pending_mode%0d", k - 1), 32'(exp_q.size()), 32'd0);
    end

    // Two-word frame; a third word is queued so no underrun occurs
    cur_k = 0;
    load(0, 16'h0011);
    check("t3_underrun_cleared", 32'(tx_underrun[0]), 32'd0);
    ss_low(0);
    wait_ready(0, "t3_ready1");
    load(0, 16'h0022);
    xfer(0, 16'h0081, 16'h0011, "t3_miso_w1");
    wait_ready(0, "t3_ready2");
    load(0, 16'h0099);
    xfer(0, 16'h007E, 16'h0022, "t3_miso_w2");
    ss_high(0);
    check("t3_underrun", 32'(tx_underrun[0]), 32'd0);
    check("t3_pending", 32'(exp_q.size()), 32'd0);

    // Underrun, clear on load, load ignored while buffer full
    ss_low(0);
    xfer(0, 16'h005A, 16'h0000, "t4_miso_zero");
    ss_high(0);
    check("t4_underrun_set", 32'(tx_underrun[0]), 32'd1);
    load(0, 16'h0033);
    check("t4_underrun_clr", 32'(tx_underrun[0]), 32'd0);
    load(0, 16'h00CC);
    check("t4_ready_full", 32'(tx_ready[0]), 32'd0);
    ss_low(0);
    xfer(0, 16'h000F, 16'h0033, "t4_buffer_kept");
    ss_high(0);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    // Abort after 5 bits, then a clean frame
    load(0, 16'h006B);
    ss_low(0);
    word(0, 16'h00FF, 5, mi);
    check("t5_partial_miso", 32'(mi), 32'h68);
    ss_high(0);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_miso", 32'(miso[0]), 32'd0);
    check("t5_no_rx", 32'(exp_q.size()), 32'd0);
    load(0, 16'h0096);
    ss_low(0);
    xfer(0, 16'h00C3, 16'h0096, "t5_next_miso");
    ss_high(0);
    check("t5_next_rx", 32'(rx_of(0)), 32'hC3);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame after 3 bits; rest of frame must be ignored
    load(0, 16'h005A);
    ss_low(0);
    word(0, 16'h00A5, 3, mi);
    load(0, 16'h0044);
    check("t6_ready_before", 32'(tx_ready[0]), 32'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_reset_vals(0, "t6_after_rst");
    word(0, 16'h00FF, 5, mi);
    check("t6_ignored_miso", 32'(mi), 32'd0);
    check("t6_ignored_busy", 32'(busy[0]), 32'd0);
    ss_high(0);
    check("t6_no_rx", 32'(exp_q.size()), 32'd0);
    load(0, 16'h003E);
    ss_low(0);
    xfer(0, 16'h00E7, 16'h003E, "t6_next_miso");
    ss_high(0);
    check("t6_next_rx", 32'(rx_of(0)), 32'hE7);
    check("t6_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
